execute_sequencer: RTL

Multi-cycle controller for the Y86-64 execute stage. It owns one shared 64-bit ALU (op 00 add, 01 sub, 10 and, 11 xor) and the architectural condition-code register. It latches an instruction's fields, selects ALU operands and function per icode, and captures valE and overflow. It commits ZF/SF/OF for OPq, evaluates the cmovXX/jXX Condition signal, and reports completion to the stage sequencer through a Start/Ready/Done handshake.

---
 rtl/execute_sequencer_if.sv | 27 ++
 rtl/execute_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_sequencer_if.sv
// Start/Ready/Done handshake and instruction/result bus between the stage
// sequencer (master) and the execute sequencer (slave).
interface execute_sequencer_if;
    logic        Start;
    logic        Abort;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        Ready;
    logic        Done;
    logic [63:0] valE;
    logic        Condition;
    logic [0:2]  ConditionCodes;
    logic        Error;

    modport master (
        output Start, Abort, icode, ifun, valA, valB, valC,
        input  Ready, Done, valE, Condition, ConditionCodes, Error
    );

    modport slave (
        input  Start, Abort, icode, ifun, valA, valB, valC,
        output Ready, Done, valE, Condition, ConditionCodes, Error
    );
endinterface

// File: rtl/execute_sequencer.sv
// Y86-64 execute stage controller: one shared ALU, condition-code register,
// and a five-state IDLE/DECODE/EXEC/COND/DONE sequence per instruction.
module execute_sequencer #(
    parameter logic [63:0] STACK_STEP = 64'd8,
    parameter int unsigned WIDTH      = 64
) (
    input logic                 Clk,
    input logic                 Reset_n,
    execute_sequencer_if.slave  bus
);
    localparam int unsigned W = WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_COND   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_XOR = 2'b11;

    state_e         state_q, state_d;
    logic [3:0]     icode_q, icode_d, ifun_q, ifun_d;
    logic [W-1:0]   val_a_q, val_a_d, val_b_q, val_b_d, val_c_q, val_c_d;
    logic [W-1:0]   op_x_q, op_x_d, op_y_q, op_y_d;
    logic [1:0]     alu_fn_q, alu_fn_d;
    logic [W-1:0]   val_e_q, val_e_d;
    logic           cond_q, cond_d;
    logic           error_q, error_d;
    logic [0:2]     cc_q, cc_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;

    logic [W-1:0]   alu_res_c;
    logic           alu_of_c;
    logic           cond_eval_c;

    // Shared ALU: result = x op y, so sub computes x - y.
    always_comb begin
        alu_res_c = '0;
        alu_of_c  = 1'b0;
        unique case (alu_fn_q)
            FN_ADD: begin
                alu_res_c = op_x_q + op_y_q;
                alu_of_c  = (op_x_q[W-1] == op_y_q[W-1]) && (alu_res_c[W-1] != op_x_q[W-1]);
            end
            FN_SUB: begin
                alu_res_c = op_x_q - op_y_q;
                alu_of_c  = (op_x_q[W-1] != op_y_q[W-1]) && (alu_res_c[W-1] != op_x_q[W-1]);
            end
            FN_AND: alu_res_c = op_x_q & op_y_q;
            FN_XOR: alu_res_c = op_x_q ^ op_y_q;
        endcase
    end

    // Branch/move condition from the committed {ZF,SF,OF}.
    always_comb begin
        cond_eval_c = 1'b0;
        case (ifun_q)
            4'h0:    cond_eval_c = 1'b1;
            4'h1:    cond_eval_c = cc_q[0] | (cc_q[1] ^ cc_q[2]);
            4'h2:    cond_eval_c = cc_q[1] ^ cc_q[2];
            4'h3:    cond_eval_c = cc_q[0];
            4'h4:    cond_eval_c = ~cc_q[0];
            4'h5:    cond_eval_c = ~(cc_q[1] ^ cc_q[2]);
            4'h6:    cond_eval_c = ~cc_q[0] & ~(cc_q[1] ^ cc_q[2]);
            default: cond_eval_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        icode_d  = icode_q;
        ifun_d   = ifun_q;
        val_a_d  = val_a_q;
        val_b_d  = val_b_q;
        val_c_d  = val_c_q;
        op_x_d   = op_x_q;
        op_y_d   = op_y_q;
        alu_fn_d = alu_fn_q;
        val_e_d  = val_e_q;
        cond_d   = cond_q;
        error_d  = error_q;
        cc_d     = cc_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    icode_d = bus.icode;
                    ifun_d  = bus.ifun;
                    val_a_d = bus.valA;
                    val_b_d = bus.valB;
                    val_c_d = bus.valC;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_EXEC;
                    op_x_d   = '0;
                    op_y_d   = '0;
                    alu_fn_d = FN_ADD;
                    case (icode_q)
                        4'h0, 4'h1, 4'h7: ;
                        4'h2: op_x_d = val_a_q;
                        4'h3: op_x_d = val_c_q;
                        4'h4, 4'h5: begin
                            op_x_d = val_b_q;
                            op_y_d = val_c_q;
                        end
                        4'h6: begin
                            op_x_d   = val_b_q;
                            op_y_d   = val_a_q;
                            alu_fn_d = ifun_q[1:0];
                        end
                        4'h8, 4'hA: begin
                            op_x_d   = val_b_q;
                            op_y_d   = W'(STACK_STEP);
                            alu_fn_d = FN_SUB;
                        end
                        4'h9, 4'hB: begin
                            op_x_d = val_b_q;
                            op_y_d = W'(STACK_STEP);
                        end
                        default: begin
                            // Illegal icode: report at once without touching the ALU path.
                            error_d = 1'b1;
                            val_e_d = '0;
                            cond_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    val_e_d = alu_res_c;
                    error_d = 1'b0;
                    if (icode_q == 4'h6) begin
                        cc_d = {alu_res_c == '0, alu_res_c[W-1], alu_of_c};
                    end
                    state_d = S_COND;
                end
            end
            S_COND: begin
                cond_d  = (icode_q == 4'h2 || icode_q == 4'h7) ? cond_eval_c : 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            icode_q  <= '0;
            ifun_q   <= '0;
            val_a_q  <= '0;
            val_b_q  <= '0;
            val_c_q  <= '0;
            op_x_q   <= '0;
            op_y_q   <= '0;
            alu_fn_q <= FN_ADD;
            val_e_q  <= '0;
            cond_q   <= 1'b1;
            error_q  <= 1'b0;
            cc_q     <= 3'b100;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            icode_q  <= icode_d;
            ifun_q   <= ifun_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            val_c_q  <= val_c_d;
            op_x_q   <= op_x_d;
            op_y_q   <= op_y_d;
            alu_fn_q <= alu_fn_d;
            val_e_q  <= val_e_d;
            cond_q   <= cond_d;
            error_q  <= error_d;
            cc_q     <= cc_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.Ready          = ready_q;
    assign bus.Done           = done_q;
    assign bus.valE           = 64'(val_e_q);
    assign bus.Condition      = cond_q;
    assign bus.ConditionCodes = cc_q;
    assign bus.Error          = error_q;
endmodule
